parity_nibble_receiver: RTL and testbench

PARITY_NIBBLE_RECEIVER -- requirements
Module: PARITY_NIBBLE_RECEIVER

---
 rtl/parity_nibble_receiver_pkg.sv | 19 +
 rtl/parity_nibble_receiver_parity4_check.sv | 14 +
 rtl/parity_nibble_receiver.sv | 111 +++++++++++
 tb/tb_parity_nibble_receiver.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/parity_nibble_receiver_pkg.sv
// Shared constants and state encoding for the serial parity nibble receiver.
package parity_nibble_receiver_pkg;

  // Data bits per frame (only 4 is supported).
  localparam int unsigned DATA_W    = 4;
  // Frame = DATA_W data bits followed by one parity bit.
  localparam int unsigned FRAME_LEN = 5;
  // Bit counter width, covering counts 0..FRAME_LEN-1.
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN);
  // Default error counter width.
  localparam int unsigned ERR_W_DEF = 8;

  // SHIFT covers counts 0..3, PARITY is count 4.
  typedef enum logic {
    SHIFT  = 1'b0,
    PARITY = 1'b1
  } state_t;

endpackage

// File: rtl/parity_nibble_receiver_parity4_check.sv
// Combinational parity check for one nibble frame.
//   data   : 4 received data bits
//   parity : received parity bit
//   err_c  : 1 when parity differs from d0^d1^d2^d3
module parity_nibble_receiver_parity4_check (
  input  logic [3:0] data,
  input  logic       parity,
  output logic       err_c
);

  // Expected parity is 1 for an odd number of ones in data.
  assign err_c = (^data) ^ parity;

endmodule

// File: rtl/parity_nibble_receiver.sv
// Serial frame receiver: 4 data bits LSB-first then 1 parity bit, delivered
// as a nibble plus parity-error flag over a valid/ready output with a
// saturating count of errored frames.
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid/in_ready/in_bit      : serial bit input handshake
//   out_valid/out_ready           : frame output handshake
//   out_data, out_perr            : received nibble and parity-error flag
//   err_cnt                       : saturating count of errored frames
module parity_nibble_receiver #(
  parameter int unsigned DATA_W = parity_nibble_receiver_pkg::DATA_W,
  parameter int unsigned ERR_W  = parity_nibble_receiver_pkg::ERR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic [ERR_W-1:0]  err_cnt
);

  import parity_nibble_receiver_pkg::*;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               out_valid_d;
  logic [DATA_W-1:0]  out_data_d;
  logic               out_perr_d;
  logic [ERR_W-1:0]   err_cnt_d;
  logic               accept;
  logic               perr_c;

  // Parity check on the collected nibble against the bit currently on in_bit.
  parity_nibble_receiver_parity4_check u_check (
    .data   (shift_q),
    .parity (in_bit),
    .err_c  (perr_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SHIFT;
      cnt_q     <= '0;
      shift_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_perr  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_perr  <= out_perr_d;
      err_cnt   <= err_cnt_d;
    end
  end

  // Next-state, handshake and output-register load logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_perr_d  = out_perr;
    err_cnt_d   = err_cnt;

    // Only the parity bit needs a free output slot; a same-cycle consume frees it.
    in_ready = !((state_q == PARITY) && out_valid && !out_ready);
    accept   = in_valid && in_ready;

    if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      case (state_q)
        SHIFT: begin
          shift_d[cnt_q[1:0]] = in_bit;
          cnt_d               = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          // A load overrides any concurrent consume, so out_valid stays high.
          cnt_d       = '0;
          state_d     = SHIFT;
          out_valid_d = 1'b1;
          out_data_d  = shift_q;
          out_perr_d  = perr_c;
          if (perr_c && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt + ERR_W'(1);
          end
        end
        default: begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_nibble_receiver.sv
// Self-checking bench for parity_nibble_receiver: directed frames plus
// randomized traffic compared against a frame-level reference model.
module tb_parity_nibble_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_perr;
  logic [7:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: bits collected so far, and the output slot.
  bit       m_bits[$];
  bit       m_full;
  bit [3:0] m_data;
  bit       m_perr;
  int       m_err;

  always #5 clk = ~clk;

  parity_nibble_receiver #(.DATA_W(4), .ERR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_perr  (out_perr),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_bits.delete();
    m_full = 1'b0;
    m_data = 4'h0;
    m_perr = 1'b0;
    m_err  = 0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  // One clock cycle: drive inputs, compare DUT against model at negedge,
  // advance the model by the handshake rules, then move past the posedge.
  task automatic step(input bit v, input bit b, input bit r);
    bit       exp_ready;
    bit       acc;
    bit [3:0] d;
    in_valid  = v;
    in_bit    = b;
    out_ready = r;
    @(negedge clk);
    exp_ready = !(m_bits.size() == 4 && m_full && !r);
    check("in_ready",  32'(in_ready),  32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(m_full));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_perr",  32'(out_perr),  32'(m_perr));
    check("err_cnt",   32'(err_cnt),   32'(m_err));
    acc = v && exp_ready;
    if (m_full && r) m_full = 1'b0;
    if (acc) begin
      if (m_bits.size() < 4) begin
        m_bits.push_back(b);
      end else begin
        for (int i = 0; i < 4; i++) d[i] = m_bits[i];
        m_data = d;
        m_perr = (($countones(d) % 2) == 1) != b;
        m_full = 1'b1;
        if (m_perr && m_err < 255) m_err++;
        m_bits.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit [3:0] d, input bit p, input bit r);
    for (int i = 0; i < 4; i++) step(1'b1, d[i], r);
    step(1'b1, p, r);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    model_clear();
    do_reset();
    do_reset();

    // Reset values.
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_perr",  32'(out_perr),  32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // Bits 1,0,1,1 then parity 1: good frame 4'b1101.
    send_frame(4'b1101, 1'b1, 1'b0);
    check("f1_valid", 32'(out_valid), 32'd1);
    check("f1_data",  32'(out_data),  32'h d);
    check("f1_perr",  32'(out_perr),  32'd0);
    check("f1_err",   32'(err_cnt),   32'd0);
    step(1'b0, 1'b0, 1'b1);
    check("f1_consumed", 32'(out_valid), 32'd0);

    // Bits 1,1,0,0 then parity 1: errored frame 4'b0011.
    send_frame(4'b0011, 1'b1, 1'b0);
    check("f2_data", 32'(out_data), 32'h3);
    check("f2_perr", 32'(out_perr), 32'd1);
    check("f2_err",  32'(err_cnt),  32'd1);
    step(1'b0, 1'b0, 1'b1);

    // Backpressure: second frame stalls on its parity bit, then loads with no bubble.
    send_frame(4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, i[0] ^ i[1], 1'b0);
    in_valid  = 1'b1;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    #1;
    check("stall_ready", 32'(in_ready), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("stall_hold_valid", 32'(out_valid), 32'd1);
    check("stall_hold_data",  32'(out_data),  32'h1);
    step(1'b1, 1'b0, 1'b1);
    check("nobubble_valid", 32'(out_valid), 32'd1);
    check("nobubble_data",  32'(out_data),  32'h6);
    check("nobubble_perr",  32'(out_perr),  32'd0);
    step(1'b0, 1'b0, 1'b1);

    // Reset mid-frame, then 0,1,0,0 with parity 1.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    do_reset();
    send_frame(4'b0010, 1'b1, 1'b1);
    check("rstmid_data", 32'(out_data), 32'h2);
    check("rstmid_perr", 32'(out_perr), 32'd0);

    // Pending frame dropped by reset.
    do_reset();
    check("rst_drop_valid", 32'(out_valid), 32'd0);

    // 257 errored frames: err_cnt saturates at 255.
    for (int f = 0; f < 257; f++) send_frame(4'b0000, 1'b1, 1'b1);
    check("sat_err_cnt", 32'(err_cnt), 32'd255);
    send_frame(4'b0111, 1'b0, 1'b1);
    check("sat_hold", 32'(err_cnt), 32'd255);
    check("sat_perr", 32'(out_perr), 32'd1);

    // Randomized gaps, backpressure, bits and occasional resets.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 65, 1'($urandom), $urandom_range(0, 99) < 55);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
